// File: rtl/branch_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : branch_issue_sequencer
// Description : Queues decoded branch-class instructions in a small FIFO and
//               issues them one at a time into a fixed-latency branch unit
//               that has no squash path. The unit's taken indication is
//               sampled at resolve time; a taken branch or an external flush
//               discards every queued (wrong-path) entry.
// Ports       : clock_i        - clock, all state on the rising edge
//               reset_i        - asynchronous active-low reset
//               stall_i        - holds issue; the resolve wait keeps counting
//               flush_i        - external flush, clears the FIFO, blocks issue
//               inValid_i      - dispatch offers an entry
//               inPayload_i    - entry data
//               inReady_o      - entry accepted this cycle (combinational)
//               issueEnable_o  - one-cycle enable pulse to the branch unit
//               issuePayload_o - instruction fields, valid with issueEnable_o
//               isBranching_i  - branch unit taken indication
//               resolved_o     - one-cycle pulse, in-flight branch resolved
//               taken_o        - resolution result, valid with resolved_o
//               occupancy_o    - entries currently held in the FIFO
//               busy_o         - sequencer is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module branch_issue_sequencer #(
    parameter int DEPTH          = 4,
    parameter int PAYLOAD_WIDTH  = 160,
    parameter int BRANCH_LATENCY = 3
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     inValid_i,
    input  logic [PAYLOAD_WIDTH-1:0] inPayload_i,
    output logic                     inReady_o,
    output logic                     issueEnable_o,
    output logic [PAYLOAD_WIDTH-1:0] issuePayload_o,
    input  logic                     isBranching_i,
    output logic                     resolved_o,
    output logic                     taken_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     busy_o
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_OCC_W  = $clog2(DEPTH) + 1;
    localparam int c_WAIT_W = $clog2(BRANCH_LATENCY + 2);

    localparam logic [c_OCC_W-1:0]  c_DEPTH     = c_OCC_W'(DEPTH);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(BRANCH_LATENCY + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                   state_q,     state_d;
    logic [c_PTR_W-1:0]       wr_ptr_q,    wr_ptr_d;
    logic [c_PTR_W-1:0]       rd_ptr_q,    rd_ptr_d;
    logic [c_OCC_W-1:0]       occ_q,       occ_d;
    logic [c_WAIT_W-1:0]      wait_q,      wait_d;
    logic                     issue_en_q,  issue_en_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q,   payload_d;
    logic                     resolved_q,  resolved_d;
    logic                     taken_q,     taken_d;

    logic [PAYLOAD_WIDTH-1:0] mem_q [DEPTH];

    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_clear;

    // Readiness excluding reset; the reset gating is applied only on the
    // output so the push enable never depends on the async reset net.
    assign w_ready = (occ_q < c_DEPTH) && (state_q != S_FLUSH) && !flush_i;
    assign w_push  = inValid_i && w_ready;
    assign w_pop   = (state_q == S_IDLE) && (occ_q != '0) && !stall_i && !flush_i;
    // Either a taken branch (FLUSH state) or an external flush empties the queue.
    assign w_clear = flush_i || (state_q == S_FLUSH);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        wait_d     = wait_q;
        issue_en_d = 1'b0;
        payload_d  = payload_q;
        resolved_d = 1'b0;
        taken_d    = taken_q;

        if (w_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    issue_en_d = 1'b1;
                    payload_d  = mem_q[rd_ptr_q];
                    wait_d     = c_WAIT_LOAD;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // Counts down unconditionally: the branch unit cannot be
                // stalled, so its result arrives on a fixed schedule.
                wait_d = wait_q - 1'b1;
                if (wait_q == c_WAIT_LAST) begin
                    resolved_d = 1'b1;
                    taken_d    = isBranching_i;
                    state_d    = isBranching_i ? S_FLUSH : S_IDLE;
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            wait_q     <= '0;
            issue_en_q <= 1'b0;
            payload_q  <= '0;
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            wait_q     <= wait_d;
            issue_en_q <= issue_en_d;
            payload_q  <= payload_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
        end
    end

    // Storage needs no reset: occupancy guards every read.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= inPayload_i;
        end
    end

    assign inReady_o      = reset_i && w_ready;
    assign issueEnable_o  = issue_en_q;
    assign issuePayload_o = payload_q;
    assign resolved_o     = resolved_q;
    assign taken_o        = taken_q;
    assign occupancy_o    = occ_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_branch_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_issue_sequencer
// Description : Directed self-checking bench for branch_issue_sequencer.
//               Each scenario task drives stimulus and compares outputs
//               against hand-derived expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_issue_sequencer;

    localparam int PW = 160;

    logic          clock_i;
    logic          reset_i;
    logic          stall_i;
    logic          flush_i;
    logic          inValid_i;
    logic [PW-1:0] inPayload_i;
    logic          inReady_o;
    logic          issueEnable_o;
    logic [PW-1:0] issuePayload_o;
    logic          isBranching_i;
    logic          resolved_o;
    logic          taken_o;
    logic [2:0]    occupancy_o;
    logic          busy_o;

    int errors;
    int checks;

    branch_issue_sequencer #(
        .DEPTH          (4),
        .PAYLOAD_WIDTH  (PW),
        .BRANCH_LATENCY (3)
    ) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .inValid_i      (inValid_i),
        .inPayload_i    (inPayload_i),
        .inReady_o      (inReady_o),
        .issueEnable_o  (issueEnable_o),
        .issuePayload_o (issuePayload_o),
        .isBranching_i  (isBranching_i),
        .resolved_o     (resolved_o),
        .taken_o        (taken_o),
        .occupancy_o    (occupancy_o),
        .busy_o         (busy_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // One rising edge, then settle so registered outputs are stable.
    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic push(input logic [PW-1:0] d);
        inValid_i   = 1'b1;
        inPayload_i = d;
        step();
        inValid_i   = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        step();
        checks++; if (issueEnable_o !== 1'b0) begin errors++; $display("FAIL reset_issue: got %b want 0", issueEnable_o); end
        checks++; if (issuePayload_o !== '0) begin errors++; $display("FAIL reset_payload: got %h want 0", issuePayload_o); end
        checks++; if (occupancy_o !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (inReady_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", inReady_o); end
        checks++; if ({resolved_o, taken_o} !== 2'b00) begin errors++; $display("FAIL reset_resolve: got %b want 00", {resolved_o, taken_o}); end
        reset_i = 1'b1;
        step();
        checks++; if (inReady_o !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", inReady_o); end
    endtask

    task automatic test_single_not_taken();
        logic [PW-1:0] a5;
        a5 = PW'(8'hA5);
        push(a5);                       // edge 0
        checks++; if (occupancy_o !== 3'd1) begin errors++; $display("FAIL single_occ_e0: got %0d want 1", occupancy_o); end
        checks++; if (issueEnable_o !== 1'b0) begin errors++; $display("FAIL single_noissue_e0: got %b want 0", issueEnable_o); end
        step();                         // edge 1
        checks++; if (issueEnable_o !== 1'b1) begin errors++; $display("FAIL single_issue_e1: got %b want 1", issueEnable_o); end
        checks++; if (issuePayload_o !== a5) begin errors++; $display("FAIL single_payload: got %h want %h", issuePayload_o, a5); end
        checks++; if (occupancy_o !== 3'd0) begin errors++; $display("FAIL single_occ_e1: got %0d want 0", occupancy_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy_o); end
        // Branch unit noise outside the resolve edge must be ignored.
        isBranching_i = 1'b1;
        for (int e = 2; e <= 4; e++) begin
            step();
            checks++; if ({issueEnable_o, resolved_o} !== 2'b00) begin errors++; $display("FAIL single_quiet_e%0d: got %b want 00", e, {issueEnable_o, resolved_o}); end
        end
        checks++; if (issuePayload_o !== a5) begin errors++; $display("FAIL single_payload_hold: got %h want %h", issuePayload_o, a5); end
        isBranching_i = 1'b0;
        step();                         // edge 5
        checks++; if (resolved_o !== 1'b1) begin errors++; $display("FAIL single_resolved_e5: got %b want 1", resolved_o); end
        checks++; if (taken_o !== 1'b0) begin errors++; $display("FAIL single_taken: got %b want 0", taken_o); end
        step();                         // edge 6
        checks++; if ({resolved_o, busy_o, occupancy_o} !== 5'b0_0_000) begin errors++; $display("FAIL single_idle_e6: got %b want 00000", {resolved_o, busy_o, occupancy_o}); end
    endtask

    task automatic test_fill_to_depth();
        logic [PW-1:0] p [4];
        logic [PW-1:0] p5;
        for (int i = 0; i < 4; i++) p[i] = {5{32'h1000_0000 + 32'(i + 1)}};
        p5 = {5{32'hBAD0_0005}};
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) push(p[i]);
        checks++; if (occupancy_o !== 3'd4) begin errors++; $display("FAIL fill_occ: got %0d want 4", occupancy_o); end
        checks++; if (inReady_o !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", inReady_o); end
        checks++; if (issueEnable_o !== 1'b0) begin errors++; $display("FAIL fill_stalled_issue: got %b want 0", issueEnable_o); end
        push(p5);
        checks++; if (occupancy_o !== 3'd4) begin errors++; $display("FAIL fill_5th_dropped: got %0d want 4", occupancy_o); end
        stall_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++; if (issueEnable_o !== (c % 5 == 0)) begin errors++; $display("FAIL fill_issue_c%0d: got %b want %b", c, issueEnable_o, (c % 5 == 0)); end
            if (c % 5 == 0) begin
                checks++; if (issuePayload_o !== p[c / 5]) begin errors++; $display("FAIL fill_order_c%0d: got %h want %h", c, issuePayload_o, p[c / 5]); end
            end
            checks++; if (resolved_o !== (c % 5 == 4)) begin errors++; $display("FAIL fill_resolved_c%0d: got %b want %b", c, resolved_o, (c % 5 == 4)); end
        end
        step();
        checks++; if ({busy_o, occupancy_o} !== 4'b0_000) begin errors++; $display("FAIL fill_drained: got %b want 0000", {busy_o, occupancy_o}); end
    endtask

    task automatic test_taken_flush();
        logic [PW-1:0] t0;
        t0 = {5{32'h7A7E_0000}};
        stall_i = 1'b1;
        push(t0);
        push({5{32'h7A7E_0001}});
        push({5{32'h7A7E_0002}});
        stall_i = 1'b0;
        step();                         // c=0 issue
        checks++; if ({issueEnable_o, occupancy_o} !== 4'b1_010) begin errors++; $display("FAIL taken_issue: got %b want 1010", {issueEnable_o, occupancy_o}); end
        checks++; if (issuePayload_o !== t0) begin errors++; $display("FAIL taken_payload: got %h want %h", issuePayload_o, t0); end
        step(); step(); step();         // c=1..3
        isBranching_i = 1'b1;
        step();                         // c=4 resolve
        isBranching_i = 1'b0;
        checks++; if ({resolved_o, taken_o} !== 2'b11) begin errors++; $display("FAIL taken_resolve: got %b want 11", {resolved_o, taken_o}); end
        checks++; if ({busy_o, inReady_o} !== 2'b10) begin errors++; $display("FAIL taken_flush_state: got %b want 10", {busy_o, inReady_o}); end
        step();                         // c=5 FLUSH edge
        checks++; if ({occupancy_o, busy_o} !== 4'b000_0) begin errors++; $display("FAIL taken_cleared: got %b want 0000", {occupancy_o, busy_o}); end
        checks++; if (taken_o !== 1'b1) begin errors++; $display("FAIL taken_hold: got %b want 1", taken_o); end
        for (int c = 6; c <= 8; c++) begin
            step();
            checks++; if (issueEnable_o !== 1'b0) begin errors++; $display("FAIL taken_no_issue_c%0d: got %b want 0", c, issueEnable_o); end
        end
    endtask

    task automatic test_async_reset_wait();
        stall_i = 1'b1;
        push({5{32'h0EE5_0001}});
        push({5{32'h0EE5_0002}});
        stall_i = 1'b0;
        step();                         // issue, waitCnt loaded
        step(); step();
        checks++; if ({busy_o, occupancy_o, taken_o} !== 5'b1_001_1) begin errors++; $display("FAIL areset_pre: got %b want 10011", {busy_o, occupancy_o, taken_o}); end
        #2;
        reset_i = 1'b0;
        #1;
        checks++; if ({issueEnable_o, resolved_o, taken_o, busy_o, inReady_o} !== 5'b0) begin errors++; $display("FAIL areset_flags: got %b want 00000", {issueEnable_o, resolved_o, taken_o, busy_o, inReady_o}); end
        checks++; if ({occupancy_o, issuePayload_o} !== '0) begin errors++; $display("FAIL areset_data: occ %0d payload %h want 0", occupancy_o, issuePayload_o); end
        isBranching_i = 1'b1;
        step();
        reset_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++; if ({issueEnable_o, resolved_o, occupancy_o} !== 5'b0) begin errors++; $display("FAIL areset_after_c%0d: got %b want 00000", c, {issueEnable_o, resolved_o, occupancy_o}); end
        end
        isBranching_i = 1'b0;
    endtask

    task automatic test_flush_in_wait();
        logic [PW-1:0] nx;
        nx = {5{32'hF1F0_0009}};
        stall_i = 1'b1;
        push({5{32'hF1F0_0001}});
        push({5{32'hF1F0_0002}});
        push({5{32'hF1F0_0003}});
        stall_i = 1'b0;
        step();                         // c=0 issue, occ 2
        step();                         // c=1 waitCnt now 3
        flush_i     = 1'b1;
        inValid_i   = 1'b1;
        inPayload_i = {5{32'hDEAD_DEAD}};
        #1;
        checks++; if (inReady_o !== 1'b0) begin errors++; $display("FAIL xflush_ready: got %b want 0", inReady_o); end
        step();                         // c=2 flush edge
        flush_i   = 1'b0;
        inValid_i = 1'b0;
        checks++; if ({occupancy_o, busy_o} !== 4'b000_1) begin errors++; $display("FAIL xflush_cleared: got %b want 0001", {occupancy_o, busy_o}); end
        step();                         // c=3
        checks++; if (resolved_o !== 1'b0) begin errors++; $display("FAIL xflush_early: got %b want 0", resolved_o); end
        step();                         // c=4 resolve on schedule
        checks++; if ({resolved_o, taken_o} !== 2'b10) begin errors++; $display("FAIL xflush_resolve: got %b want 10", {resolved_o, taken_o}); end
        push(nx);                       // c=5
        step();                         // c=6
        checks++; if (issueEnable_o !== 1'b1 || issuePayload_o !== nx) begin errors++; $display("FAIL xflush_next_issue: en %b payload %h want 1 %h", issueEnable_o, issuePayload_o, nx); end
        step(); step(); step();
        step();                         // c=10
        checks++; if (resolved_o !== 1'b1) begin errors++; $display("FAIL xflush_next_resolve: got %b want 1", resolved_o); end
    endtask

    task automatic test_stall_in_wait();
        logic [PW-1:0] s1;
        s1 = {5{32'h57A1_0002}};
        stall_i = 1'b1;
        push({5{32'h57A1_0001}});
        push(s1);
        stall_i = 1'b0;
        step();                         // c=0 issue
        stall_i = 1'b1;
        checks++; if (issueEnable_o !== 1'b1) begin errors++; $display("FAIL stall_first_issue: got %b want 1", issueEnable_o); end
        step(); step(); step();
        step();                         // c=4
        checks++; if (resolved_o !== 1'b1) begin errors++; $display("FAIL stall_resolve_timing: got %b want 1", resolved_o); end
        step(); step();                 // c=5,6
        checks++; if ({issueEnable_o, occupancy_o} !== 4'b0_001) begin errors++; $display("FAIL stall_held: got %b want 0001", {issueEnable_o, occupancy_o}); end
        stall_i = 1'b0;
        step();                         // c=7
        checks++; if (issueEnable_o !== 1'b1 || issuePayload_o !== s1) begin errors++; $display("FAIL stall_release_issue: en %b payload %h want 1 %h", issueEnable_o, issuePayload_o, s1); end
        step(); step(); step();
        step();                         // c=11
        checks++; if (resolved_o !== 1'b1) begin errors++; $display("FAIL stall_second_resolve: got %b want 1", resolved_o); end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset_i       = 1'b0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        inValid_i     = 1'b0;
        inPayload_i   = '0;
        isBranching_i = 1'b0;

        test_reset();
        test_single_not_taken();
        test_fill_to_depth();
        test_taken_flush();
        test_async_reset_wait();
        test_flush_in_wait();
        test_stall_in_wait();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
